// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32 core: FETCH/DECODE/EXEC/MEM/WB strobes,
// wait-state handling with bus timeout, illegal-instruction trap, halt/resume and perf counters.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = 8,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ready,
  input  logic                 illegal_instr,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 halt_req,
  input  logic                 trap_ack,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 exec_en,
  output logic                 wb_en,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic                 data_phase,
  output logic                 trap,
  output logic [2:0]           trap_cause,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_NONE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [TO_WIDTH-1:0]  TIMEOUT_VAL = TO_WIDTH'(MEM_TIMEOUT);
  localparam logic [TO_WIDTH-1:0]  WAIT_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = 1;

  state_t              state_reg;
  state_t              state_next;
  state_t              fetch_target;
  logic [TO_WIDTH-1:0] wait_reg;
  logic                load_reg;
  logic                load_next;
  logic [2:0]          cause_next;
  logic                retire;
  logic                timeout;
  logic                waiting;

  assign state = state_reg;

  always_comb begin
    state_next   = state_reg;
    load_next    = load_reg;
    cause_next   = trap_cause;
    retire       = 1'b0;
    // Any path back to FETCH is diverted to HALT at an instruction boundary.
    fetch_target = halt_req ? S_HALT : S_FETCH;
    timeout      = (MEM_TIMEOUT != 0) && (wait_reg == TIMEOUT_VAL) && !mem_ready;
    case (state_reg)
      S_NONE:   state_next = fetch_target;
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 3'd1;
        end
      end
      S_DECODE: begin
        if (illegal_instr) begin
          state_next = S_TRAP;
          cause_next = 3'd2;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_next = S_MEM;
          load_next  = is_load;
        end else begin
          state_next = fetch_target;
          retire     = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (load_reg) begin
            state_next = S_WB;
          end else begin
            state_next = fetch_target;
            retire     = 1'b1;
          end
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = load_reg ? 3'd3 : 3'd4;
        end
      end
      S_WB: begin
        state_next = fetch_target;
        retire     = 1'b1;
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_next = fetch_target;
          cause_next = 3'd0;
        end
      end
      S_HALT: begin
        if (!halt_req) state_next = S_FETCH;
      end
      default:  state_next = S_NONE;
    endcase
  end

  // A wait is a FETCH or MEM cycle that holds in place; every entry restarts the count.
  assign waiting = (state_next == state_reg) && ((state_reg == S_FETCH) || (state_reg == S_MEM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_NONE;
      wait_reg    <= '0;
      load_reg    <= 1'b0;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      wb_en       <= 1'b0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      data_phase  <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= 3'd0;
      halted      <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= waiting ? wait_reg + WAIT_ONE : '0;
      load_reg    <= load_next;
      fetch_en    <= (state_next == S_FETCH);
      decode_en   <= (state_next == S_DECODE);
      exec_en     <= (state_next == S_EXEC);
      wb_en       <= (state_next == S_WB);
      mem_ren     <= (state_next == S_FETCH) || ((state_next == S_MEM) && load_next);
      mem_wen     <= (state_next == S_MEM) && !load_next;
      data_phase  <= (state_next == S_MEM);
      trap        <= (state_next == S_TRAP);
      trap_cause  <= cause_next;
      halted      <= (state_next == S_HALT);
      cycle_cnt   <= cycle_cnt + CNT_ONE;
      if (retire) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle vector table plus reset-in-flight sequences.
module tb_core_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic mem_ready, illegal_instr, is_load, is_store, halt_req, trap_ack;
  logic fetch_en, decode_en, exec_en, wb_en, mem_ren, mem_wen, data_phase, trap, halted;
  logic [2:0]  trap_cause, state;
  logic [63:0] cycle_cnt, instret_cnt;

  logic w_fetch_en, w_decode_en, w_exec_en, w_wb_en, w_mem_ren, w_mem_wen;
  logic w_data_phase, w_trap, w_halted;
  logic [2:0] w_trap_cause, w_state;
  logic [3:0] w_cycle_cnt, w_instret_cnt;

  int checks = 0;
  int failures = 0;
  int exec_pulses = 0;

  always #5 clk = ~clk;

  core_sequencer #(.MEM_TIMEOUT(4), .TO_WIDTH(8), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .illegal_instr(illegal_instr),
    .is_load(is_load), .is_store(is_store), .halt_req(halt_req), .trap_ack(trap_ack),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .data_phase(data_phase), .trap(trap),
    .trap_cause(trap_cause), .halted(halted), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Narrow-counter instance, used only to observe cycle_cnt wrap.
  core_sequencer #(.MEM_TIMEOUT(255), .TO_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .illegal_instr(illegal_instr),
    .is_load(is_load), .is_store(is_store), .halt_req(halt_req), .trap_ack(trap_ack),
    .fetch_en(w_fetch_en), .decode_en(w_decode_en), .exec_en(w_exec_en), .wb_en(w_wb_en),
    .mem_ren(w_mem_ren), .mem_wen(w_mem_wen), .data_phase(w_data_phase), .trap(w_trap),
    .trap_cause(w_trap_cause), .halted(w_halted), .state(w_state),
    .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  // Output pack order: fetch,decode,exec,wb,ren,wen,data_phase,trap,halted
  localparam logic [8:0] O_0  = 9'b000000000;
  localparam logic [8:0] O_F  = 9'b100010000;
  localparam logic [8:0] O_D  = 9'b010000000;
  localparam logic [8:0] O_E  = 9'b001000000;
  localparam logic [8:0] O_W  = 9'b000100000;
  localparam logic [8:0] O_ML = 9'b000010100;
  localparam logic [8:0] O_MS = 9'b000001100;
  localparam logic [8:0] O_T  = 9'b000000010;
  localparam logic [8:0] O_H  = 9'b000000001;

  // Input pack order: mem_ready,illegal_instr,is_load,is_store,halt_req,trap_ack
  typedef struct {
    logic [5:0] in;
    logic [2:0] st;
    logic [8:0] outs;
    logic [2:0] cause;
    int         instret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs_now();
    return {fetch_en, decode_en, exec_en, wb_en, mem_ren, mem_wen, data_phase, trap, halted};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [5:0] in, input logic [2:0] st, input logic [8:0] outs,
                      input logic [2:0] cause, input int instret, input int rep = 1);
    vec_t v;
    v.in = in; v.st = st; v.outs = outs; v.cause = cause; v.instret = instret;
    for (int k = 0; k < rep; k++) vecs.push_back(v);
  endtask

  task automatic cyc(input logic [5:0] in);
    {mem_ready, illegal_instr, is_load, is_store, halt_req, trap_ack} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_outs"}, 64'(outs_now()), 64'(O_0));
    chk({tag, "_cause"}, 64'(trap_cause), 64'd0);
    chk({tag, "_cycle"}, cycle_cnt, 64'd0);
    chk({tag, "_instret"}, instret_cnt, 64'd0);
    chk({tag, "_w4cycle"}, 64'(w_cycle_cnt), 64'd0);
  endtask

  initial begin
    // Three ALU instructions, zero wait states
    addv(6'b100000, 3'd1, O_F, 3'd0, 0);
    addv(6'b100000, 3'd2, O_D, 3'd0, 0);
    addv(6'b100000, 3'd3, O_E, 3'd0, 0);
    addv(6'b100000, 3'd1, O_F, 3'd0, 1);
    addv(6'b100000, 3'd2, O_D, 3'd0, 1);
    addv(6'b100000, 3'd3, O_E, 3'd0, 1);
    addv(6'b100000, 3'd1, O_F, 3'd0, 2);
    addv(6'b100000, 3'd2, O_D, 3'd0, 2);
    addv(6'b100000, 3'd3, O_E, 3'd0, 2);
    addv(6'b100000, 3'd1, O_F, 3'd0, 3);
    // Load with two wait states in MEM
    addv(6'b100000, 3'd2, O_D, 3'd0, 3);
    addv(6'b100000, 3'd3, O_E, 3'd0, 3);
    addv(6'b101000, 3'd4, O_ML, 3'd0, 3);
    addv(6'b000000, 3'd4, O_ML, 3'd0, 3, 2);
    addv(6'b100000, 3'd5, O_W, 3'd0, 3);
    addv(6'b100000, 3'd1, O_F, 3'd0, 4);
    // Store with two wait states
    addv(6'b100000, 3'd2, O_D, 3'd0, 4);
    addv(6'b100000, 3'd3, O_E, 3'd0, 4);
    addv(6'b000100, 3'd4, O_MS, 3'd0, 4);
    addv(6'b000000, 3'd4, O_MS, 3'd0, 4, 2);
    addv(6'b100000, 3'd1, O_F, 3'd0, 5);
    // Store with halt_req raised in EXEC, then resume
    addv(6'b100000, 3'd2, O_D, 3'd0, 5);
    addv(6'b100000, 3'd3, O_E, 3'd0, 5);
    addv(6'b000110, 3'd4, O_MS, 3'd0, 5);
    addv(6'b100010, 3'd7, O_H, 3'd0, 6);
    addv(6'b000010, 3'd7, O_H, 3'd0, 6);
    addv(6'b000000, 3'd1, O_F, 3'd0, 6);
    // Illegal instruction
    addv(6'b100000, 3'd2, O_D, 3'd0, 6);
    addv(6'b010000, 3'd6, O_T, 3'd2, 6);
    addv(6'b000000, 3'd6, O_T, 3'd2, 6);
    addv(6'b000001, 3'd1, O_F, 3'd0, 6);
    // Fetch timeout after 5 FETCH cycles
    addv(6'b000000, 3'd1, O_F, 3'd0, 6, 4);
    addv(6'b000000, 3'd6, O_T, 3'd1, 6);
    addv(6'b000000, 3'd6, O_T, 3'd1, 6);
    addv(6'b000001, 3'd1, O_F, 3'd0, 6);
    // mem_ready on the timeout cycle wins
    addv(6'b000000, 3'd1, O_F, 3'd0, 6, 4);
    addv(6'b100000, 3'd2, O_D, 3'd0, 6);
    addv(6'b100000, 3'd3, O_E, 3'd0, 6);
    addv(6'b000000, 3'd1, O_F, 3'd0, 7);
    // halt_req during fetch timeout: trap first, halt on exit
    addv(6'b000010, 3'd1, O_F, 3'd0, 7, 4);
    addv(6'b000010, 3'd6, O_T, 3'd1, 7);
    addv(6'b000011, 3'd7, O_H, 3'd0, 7);
    addv(6'b000000, 3'd1, O_F, 3'd0, 7);
    // Load timeout
    addv(6'b100000, 3'd2, O_D, 3'd0, 7);
    addv(6'b100000, 3'd3, O_E, 3'd0, 7);
    addv(6'b001000, 3'd4, O_ML, 3'd0, 7);
    addv(6'b000000, 3'd4, O_ML, 3'd0, 7, 4);
    addv(6'b000000, 3'd6, O_T, 3'd3, 7);
    addv(6'b000001, 3'd1, O_F, 3'd0, 7);
    // Store timeout
    addv(6'b100000, 3'd2, O_D, 3'd0, 7);
    addv(6'b100000, 3'd3, O_E, 3'd0, 7);
    addv(6'b000100, 3'd4, O_MS, 3'd0, 7);
    addv(6'b000000, 3'd4, O_MS, 3'd0, 7, 4);
    addv(6'b000000, 3'd6, O_T, 3'd4, 7);
    addv(6'b000001, 3'd1, O_F, 3'd0, 7);
    // is_load and is_store together: load wins
    addv(6'b100000, 3'd2, O_D, 3'd0, 7);
    addv(6'b100000, 3'd3, O_E, 3'd0, 7);
    addv(6'b001100, 3'd4, O_ML, 3'd0, 7);
    addv(6'b100000, 3'd5, O_W, 3'd0, 7);
    addv(6'b100000, 3'd1, O_F, 3'd0, 8);

    rst = 1'b1;
    cyc(6'b000000);
    cyc(6'b000000);
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].in);
      $display("vec %0d in=%b state=%0d outs=%b cause=%0d instret=%0d",
               i + 1, vecs[i].in, state, outs_now(), trap_cause, instret_cnt);
      chk($sformatf("v%0d_state", i + 1), 64'(state), 64'(vecs[i].st));
      chk($sformatf("v%0d_outs", i + 1), 64'(outs_now()), 64'(vecs[i].outs));
      chk($sformatf("v%0d_cause", i + 1), 64'(trap_cause), 64'(vecs[i].cause));
      chk($sformatf("v%0d_instret", i + 1), instret_cnt, 64'(vecs[i].instret));
      if (i < 10 && exec_en) exec_pulses++;
      if (i == 9) begin
        chk("alu_cycle10", cycle_cnt, 64'd10);
        chk("alu_exec_pulses", 64'(exec_pulses), 64'd3);
      end
      if (i == 14) chk("w4_cycle15", 64'(w_cycle_cnt), 64'd15);
      if (i == 15) chk("w4_cycle_wrap", 64'(w_cycle_cnt), 64'd0);
    end
    chk("table_cycle_total", cycle_cnt, 64'(vecs.size()));

    // Reset in the middle of a MEM wait
    cyc(6'b100000);
    cyc(6'b100000);
    cyc(6'b001000);
    cyc(6'b000000);
    $display("pre-reset mem wait state=%0d outs=%b", state, outs_now());
    chk("midmem_state", 64'(state), 64'd4);
    rst = 1'b1;
    cyc(6'b000000);
    $display("reset mid-MEM state=%0d outs=%b", state, outs_now());
    chk_reset("rst_mem");
    rst = 1'b0;

    // Reset in the middle of a trap
    cyc(6'b100000);
    cyc(6'b100000);
    cyc(6'b010000);
    $display("pre-reset trap state=%0d cause=%0d", state, trap_cause);
    chk("midtrap_cause", 64'(trap_cause), 64'd2);
    rst = 1'b1;
    cyc(6'b000000);
    $display("reset mid-TRAP state=%0d outs=%b", state, outs_now());
    chk_reset("rst_trap");
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
